// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The IF stage looks up the fetch PC combinationally. A resolved
// branch from EX/MEM updates the table at the next edge, and a mispredict
// raises a combinational redirect request and bumps a saturating event counter.
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    input  logic              flush_all_i,
    output logic [31:0]       mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

    // Table storage; only the valid bits are reset, payload is don't-care while invalid
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];

    logic [31:0]        mispred_cnt_q;
    logic [31:0]        mispred_cnt_d;

    // Lookup path
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    assign lk_idx        = pc_i[IDX_W+1:2];
    assign lk_tag        = pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_target_o = pred_taken_o ? tgt_q[lk_idx] : pc_i + ADDR_W'(4);

    // Resolution path: mispredict/redirect are pure functions of the upd_* inputs
    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_pred_target_i != upd_target_i)));
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);

    // Update path
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [CTR_W-1:0]   upd_ctr_cur;
    logic [CTR_W-1:0]   upd_ctr_d;
    logic [ADDR_W-1:0]  upd_tgt_d;
    logic [ENTRIES-1:0] upd_we;

    assign upd_idx     = upd_pc_i[IDX_W+1:2];
    assign upd_tag     = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr_cur = ctr_q[upd_idx];

    // Next entry contents: saturating counter step on a hit, weakly-taken allocate on a taken miss
    always_comb begin
        upd_ctr_d = CTR_INIT;
        upd_tgt_d = upd_target_i;
        upd_we    = '0;
        if (upd_hit) begin
            if (upd_taken_i) begin
                upd_ctr_d = (upd_ctr_cur == CTR_MAX) ? CTR_MAX : upd_ctr_cur + CTR_W'(1);
            end else begin
                upd_ctr_d = (upd_ctr_cur == '0) ? '0 : upd_ctr_cur - CTR_W'(1);
                upd_tgt_d = tgt_q[upd_idx];
            end
        end
        // A not-taken miss leaves the table alone; flush drops any update
        if (upd_valid_i && !flush_all_i && (upd_hit || upd_taken_i)) begin
            upd_we[upd_idx] = 1'b1;
        end
    end

    // Valid bits: flush clears everything, otherwise written entries become valid
    always_comb begin
        valid_d = flush_all_i ? '0 : (valid_q | upd_we);
    end

    // Valid-bit register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Per-entry payload write; no reset needed since the valid bit guards it
            always_ff @(posedge clk_i) begin
                if (rst_n && upd_we[gi]) begin
                    tag_q[gi] <= upd_tag;
                    ctr_q[gi] <= upd_ctr_d;
                    tgt_q[gi] <= upd_tgt_d;
                end
            end
        end
    endgenerate

    // Mispredict counter saturates at all-ones rather than wrapping
    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (mispredict_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            mispred_cnt_q <= '0;
        end else begin
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispred_cnt_o = mispred_cnt_q;

endmodule
